// File: rtl/hex_word_tx.sv
// hex_word_tx: renders a captured binary word as ASCII hex characters (optionally followed by CR LF) on a UART byte-strobe interface
module hex_word_tx #(
    parameter int NIBBLES   = 8,
    parameter bit EOL_EN    = 1'b1,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [4*NIBBLES-1:0] i_word,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [7:0]           o_data,
    output logic                 o_stb,
    input  logic                 i_busy,
    output logic                 o_idle
);
    localparam int W    = 4 * NIBBLES;
    localparam int LAST = NIBBLES + (EOL_EN ? 2 : 0);
    localparam int IW   = (LAST > 1) ? $clog2(LAST) : 1;

    typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  word_q, word_d, word_sh;
    logic [3:0]    nib;
    logic [7:0]    hex_c;

    // state, character index and captured word registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    // sequencing: ACK is a guard cycle covering the transmitter's one-cycle busy latency
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    word_d  = i_word;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND:  state_d = i_busy ? SEND : ACK;
            ACK:   state_d = DRAIN;
            DRAIN: begin
                if (!i_busy) begin
                    if (idx_q == IW'(LAST - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_ready = (state_q == IDLE);
    assign o_idle  = o_ready;
    assign o_stb   = (state_q == SEND) && !i_busy;

    // shifting left by the index brings the current nibble to the top, MSB nibble first
    assign word_sh = word_q << {idx_q, 2'b00};
    assign nib     = word_sh[W-1 -: 4];
    assign hex_c   = (nib < 4'd10) ? 8'h30 + {4'd0, nib}
                                   : (UPPERCASE ? 8'h37 : 8'h57) + {4'd0, nib};
    assign o_data  = (EOL_EN && idx_q == IW'(NIBBLES))     ? 8'h0D :
                     (EOL_EN && idx_q == IW'(NIBBLES + 1)) ? 8'h0A : hex_c;
endmodule

// File: tb/tb_hex_word_tx.sv
// tb_hex_word_tx: directed and randomised checks of hex_word_tx against a busy-stub transmitter
module tb_hex_word_tx;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] word0 = '0, word1 = '0;
    logic        valid0 = 0, valid1 = 0;
    logic        rdy0, rdy1, stb0, stb1, idle0, idle1;
    logic [7:0]  data0, data1;
    logic        busy0, busy1;
    logic        force0 = 0;
    logic        rnd = 0;
    logic [7:0]  cnt0 = 0, cnt1 = 0;
    logic        prev0 = 0, prev1 = 0;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    int          checks = 0;
    int          errors = 0;

    localparam logic [7:0] EXP_DB [10] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    localparam logic [7:0] EXP_LC [8]  = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h61, 8'h62, 8'h63, 8'h66};

    always #5 clk = ~clk;

    hex_word_tx dut0 (
        .i_clk(clk), .i_reset(rst), .i_word(word0), .i_valid(valid0), .o_ready(rdy0),
        .o_data(data0), .o_stb(stb0), .i_busy(busy0), .o_idle(idle0)
    );

    hex_word_tx #(.NIBBLES(8), .EOL_EN(1'b0), .UPPERCASE(1'b0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_word(word1), .i_valid(valid1), .o_ready(rdy1),
        .o_data(data1), .o_stb(stb1), .i_busy(busy1), .o_idle(idle1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
        string s;
        s = up ? "0123456789ABCDEF" : "0123456789abcdef";
        return s[n];
    endfunction

    // transmitter stub: busy rises the cycle after a strobe and holds for 20 (or random 1..50) cycles
    always @(posedge clk) begin
        if (stb0) cnt0 <= rnd ? 8'($urandom_range(50, 1)) : 8'd20;
        else if (cnt0 != 0) cnt0 <= cnt0 - 1;
        if (stb1) cnt1 <= 8'd20;
        else if (cnt1 != 0) cnt1 <= cnt1 - 1;
    end
    assign busy0 = (cnt0 != 0) || force0;
    assign busy1 = (cnt1 != 0);

    // capture strobed bytes and check no strobe while busy or right after a strobe
    always @(negedge clk) begin
        if (stb0) begin
            check("proto0", {30'd0, busy0, prev0}, 32'd0);
            q0.push_back(data0);
        end
        if (stb1) begin
            check("proto1", {30'd0, busy1, prev1}, 32'd0);
            q1.push_back(data1);
        end
        prev0 <= stb0;
        prev1 <= stb1;
    end

    task automatic start(input bit sel, input logic [31:0] w);
        @(posedge clk);
        #1;
        if (sel) begin valid1 = 1; word1 = w; end
        else begin valid0 = 1; word0 = w; end
        @(posedge clk);
        #1;
        valid0 = 0;
        valid1 = 0;
    endtask

    task automatic wait_idle(input bit sel);
        bit done = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (sel ? rdy1 : rdy0) begin
                done = 1;
                break;
            end
        end
        check("idle_wait", {31'd0, done}, 32'd1);
    endtask

    task automatic cmp_fmt(input bit sel, input logic [31:0] w, input int base, input string tag);
        int n;
        logic [7:0] e, g;
        n = sel ? 8 : 10;
        for (int i = 0; i < n; i++) begin
            e = (i < 8) ? hexc(4'(w >> (28 - 4 * i)), !sel) : (i == 8 ? 8'h0D : 8'h0A);
            if (sel) g = (base + i < q1.size()) ? q1[base + i] : 8'hFF;
            else     g = (base + i < q0.size()) ? q0[base + i] : 8'hFF;
            check(tag, {24'd0, g}, {24'd0, e});
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, rdy0}, 32'd1);
        check("rst_idle", {31'd0, idle0}, 32'd1);
        check("rst_stb", {31'd0, stb0}, 32'd0);
        check("rst_data", {24'd0, data0}, 32'h30);
        @(posedge clk);
        #1 rst = 0;

        start(0, 32'hDEADBEEF);
        @(negedge clk);
        check("lat_stb", {31'd0, stb0}, 32'd1);
        check("lat_data", {24'd0, data0}, 32'h44);
        wait_idle(0);
        check("db_count", q0.size(), 32'd10);
        for (int i = 0; i < 10; i++)
            check("db_byte", {24'd0, (i < q0.size()) ? q0[i] : 8'hFF}, {24'd0, EXP_DB[i]});
        check("db_idle", {31'd0, idle0}, 32'd1);
        q0.delete();

        start(1, 32'h0123ABCF);
        wait_idle(1);
        check("lc_count", q1.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            check("lc_byte", {24'd0, (i < q1.size()) ? q1[i] : 8'hFF}, {24'd0, EXP_LC[i]});
        q1.delete();

        force0 = 1;
        start(0, 32'h12345678);
        repeat (5) begin
            @(negedge clk);
            check("hold_stb", {31'd0, stb0}, 32'd0);
            check("hold_ready", {31'd0, rdy0}, 32'd0);
        end
        @(posedge clk);
        #1 force0 = 0;
        @(negedge clk);
        check("rel_stb", {31'd0, stb0}, 32'd1);
        check("rel_data", {24'd0, data0}, 32'h31);
        wait_idle(0);
        check("hold_count", q0.size(), 32'd10);
        cmp_fmt(0, 32'h12345678, 0, "hold_byte");
        q0.delete();

        start(0, 32'hA5A5A5A5);
        begin : wait4
            bit got4 = 0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (q0.size() == 4) begin got4 = 1; break; end
            end
            check("rst_reach4", {31'd0, got4}, 32'd1);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("mid_rst_ready", {31'd0, rdy0}, 32'd1);
        check("mid_rst_stb", {31'd0, stb0}, 32'd0);
        check("mid_rst_count", q0.size(), 32'd4);
        q0.delete();
        start(0, 32'h00000001);
        wait_idle(0);
        check("post_rst_count", q0.size(), 32'd10);
        cmp_fmt(0, 32'h00000001, 0, "post_rst_byte");
        q0.delete();

        rnd = 1;
        repeat (60) begin
            logic [31:0] w;
            w = $urandom;
            start(0, w);
            wait_idle(0);
            check("rand_count", q0.size(), 32'd10);
            cmp_fmt(0, w, 0, "rand_byte");
            q0.delete();
        end
        rnd = 0;
        repeat (60) @(posedge clk);

        begin : b2b
            logic [31:0] ws [3];
            int acc;
            bit done;
            ws = '{32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
            acc = 0;
            done = 0;
            @(posedge clk);
            #1 valid0 = 1;
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                if (rdy0) begin
                    if (acc == 3) begin done = 1; break; end
                    word0 = ws[acc];
                    acc++;
                end else begin
                    word0 = $urandom;
                end
            end
            valid0 = 0;
            check("b2b_done", {31'd0, done}, 32'd1);
            check("b2b_count", q0.size(), 32'd30);
            for (int k = 0; k < 3; k++) cmp_fmt(0, ws[k], 10 * k, "b2b_byte");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
